// File: rtl/pci_initiator.sv
// pci_initiator: PCI bus master for single 1-4 beat read/write bursts.
// Optional feature macro: PCI_INIT_MASTER_ABORT_EN. When defined, the DEVSEL
// timeout counter and master abort are built. When undefined, aborted is tied
// low and the block waits in DATA until the target responds.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      local request handshake (ready only in IDLE)
//   req_write/addr/len/wdata request fields (len 0 -> 1, len > MAX_BEATS -> MAX_BEATS)
//   Frame, IRDY, CBE, AD     PCI initiator-side bus signals (AD is tri-state)
//   DEVSEL, TRDY             PCI target responses (active low)
//   rd_valid/rd_data/rd_beat read beat return, one cycle after each transfer
//   done, aborted, busy      completion pulse, master-abort pulse, not-IDLE flag
module pci_initiator #(
  parameter int         MAX_BEATS      = 4,
  parameter int         DEVSEL_TIMEOUT = 4,
  parameter logic [3:0] CMD_READ       = 4'b0010,
  parameter logic [3:0] CMD_WRITE      = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [2:0]   req_len,
  input  logic [127:0] req_wdata,
  output logic         Frame,
  output logic         IRDY,
  output logic [3:0]   CBE,
  inout  wire  [31:0]  AD,
  input  logic         DEVSEL,
  input  logic         TRDY,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic [1:0]   rd_beat,
  output logic         done,
  output logic         aborted,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic [2:0] MAX_LEN = 3'(MAX_BEATS);

  state_t         state;
  state_t         state_nxt;

  // Request fields captured at acceptance; the local port may change afterwards.
  logic [31:0]    addr_q;
  logic           write_q;
  logic [2:0]     len_q;
  logic [127:0]   wdata_q;
  logic [2:0]     idx_q;

  logic [2:0]     len_clamped;
  logic           accept;
  logic           last_beat;
  logic           xfer;
  logic           abort_hit;
  logic [3:0]     cmd;
  logic           ad_oe;
  logic [31:0]    ad_out;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Zero-length requests still move one beat; oversized ones are capped.
  always_comb begin
    len_clamped = req_len;
    if (req_len == 3'd0) begin
      len_clamped = 3'd1;
    end else if (req_len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  assign last_beat = (idx_q == (len_q - 3'd1));
  assign cmd       = write_q ? CMD_WRITE : CMD_READ;

  // IRDY is low for the whole DATA state, so a beat moves whenever TRDY is
  // low there. An abort in the same cycle wins: the beat is not counted.
  assign xfer = (state == DATA) && !TRDY && !abort_hit;

  assign AD = ad_oe ? ad_out : 'z;

`ifdef PCI_INIT_MASTER_ABORT_EN
  // Counts DATA cycles with no target claiming the cycle. Abort fires on the
  // edge that would take the count to DEVSEL_TIMEOUT.
  logic [2:0] dev_cnt;

  assign abort_hit = (state == DATA) && DEVSEL &&
                     (dev_cnt == 3'(DEVSEL_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_cnt <= 3'd0;
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
      if ((state == DATA) && DEVSEL && !abort_hit) begin
        dev_cnt <= dev_cnt + 3'd1;
      end else begin
        dev_cnt <= 3'd0;
      end
    end
  end
`else
  logic unused_abort_cfg;

  assign abort_hit        = 1'b0;
  assign aborted          = 1'b0;
  assign unused_abort_cfg = DEVSEL ^ (DEVSEL_TIMEOUT == 0);
`endif

  // State register and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      len_q    <= 3'd1;
      wdata_q  <= 128'd0;
      idx_q    <= 3'd0;
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
      rd_beat  <= 2'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        len_q   <= len_clamped;
        wdata_q <= req_wdata;
        idx_q   <= 3'd0;
      end
      if (xfer) begin
        idx_q <= idx_q + 3'd1;
        if (!write_q) begin
          rd_valid <= 1'b1;
          rd_data  <= AD;
          rd_beat  <= idx_q[1:0];
        end
        if (last_beat) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Next state and bus drive. Bus outputs follow state only, so an
  // asynchronous reset returns them to idle values without a clock edge.
  always_comb begin
    state_nxt = state;
    Frame     = 1'b1;
    IRDY      = 1'b1;
    CBE       = 4'b0000;
    ad_oe     = 1'b0;
    ad_out    = 32'd0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        Frame     = 1'b0;
        CBE       = cmd;
        ad_oe     = 1'b1;
        ad_out    = addr_q;
        state_nxt = DATA;
      end
      DATA: begin
        IRDY   = 1'b0;
        CBE    = cmd;
        // Frame rises with the final data phase.
        Frame  = last_beat;
        ad_oe  = write_q;
        ad_out = wdata_q[{idx_q[1:0], 5'b00000} +: 32];
        if (abort_hit || (xfer && last_beat)) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pci_initiator.sv
// tb_pci_initiator: directed bench for pci_initiator, acting as the PCI target.
// Inputs are driven and outputs sampled 1 time unit after each falling edge.
// The target drives 0 on AD wherever the initiator must be off the bus.
module tb_pci_initiator;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [2:0]   req_len = 3'd0;
  logic [127:0] req_wdata = 128'd0;
  logic         frame;
  logic         irdy;
  logic [3:0]   cbe;
  wire  [31:0]  ad;
  logic         devsel = 1'b1;
  logic         trdy = 1'b1;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic [1:0]   rd_beat;
  logic         done;
  logic         aborted;
  logic         busy;

  logic         tgt_oe = 1'b0;
  logic [31:0]  tgt_ad = 32'd0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;

  assign ad = tgt_oe ? tgt_ad : 'z;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  pci_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .Frame(frame), .IRDY(irdy), .CBE(cbe), .AD(ad),
    .DEVSEL(devsel), .TRDY(trdy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_beat(rd_beat),
    .done(done), .aborted(aborted), .busy(busy)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a request for exactly one rising edge; returns in the ADDR cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] l,
                       input logic [127:0] wd);
    req_write = w; req_addr = a; req_len = l; req_wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    tgt_oe = 1'b1; tgt_ad = 32'd0;
    #1;
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL reset_frame got %b want 1", frame); end
    checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL reset_irdy got %b want 1", irdy); end
    checks++; if (cbe !== 4'h0) begin errors++; $display("FAIL reset_cbe got %h want 0", cbe); end
    checks++; if (ad !== 32'd0) begin errors++; $display("FAIL reset_ad_released got %h want 0", ad); end
    checks++; if ({rd_valid, done, aborted, busy} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b want 0000", {rd_valid, done, aborted, busy}); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    rst = 1'b0;
    step();
    tgt_oe = 1'b0;
  endtask

  task automatic test_write_burst();
    issue(1'b1, 32'h10, 3'd4, {32'h1004, 32'h1003, 32'h1002, 32'h1001});
    d0 = done_cnt;
    checks++; if (ad !== 32'h10) begin errors++; $display("FAIL wr_addr_phase got %h want 10", ad); end
    checks++; if ({frame, irdy} !== 2'b01) begin errors++; $display("FAIL wr_addr_ctl got %b want 01", {frame, irdy}); end
    checks++; if (cbe !== 4'b0011) begin errors++; $display("FAIL wr_cmd got %b want 0011", cbe); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy got %b want 0", req_ready); end
    devsel = 1'b0; trdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ad !== 32'(32'h1001 + i)) begin errors++; $display("FAIL wr_beat%0d_ad got %h want %h", i, ad, 32'h1001 + i); end
      checks++; if (frame !== (i == 3)) begin errors++; $display("FAIL wr_beat%0d_frame got %b want %b", i, frame, (i == 3)); end
      checks++; if ({irdy, cbe} !== 5'b0_0011) begin errors++; $display("FAIL wr_beat%0d_irdy_cbe got %b want 00011", i, {irdy, cbe}); end
    end
    step();
    checks++; if ({done, frame, irdy, req_ready} !== 4'b1110) begin errors++; $display("FAIL wr_turn got %b want 1110", {done, frame, irdy, req_ready}); end
    tgt_oe = 1'b1; tgt_ad = 32'd0;
    #1;
    checks++; if (ad !== 32'd0) begin errors++; $display("FAIL wr_turn_ad_released got %h want 0", ad); end
    step();
    checks++; if ({req_ready, done} !== 2'b10) begin errors++; $display("FAIL wr_idle got %b want 10", {req_ready, done}); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL wr_done_count got %0d want %0d", done_cnt, d0 + 1); end
    tgt_oe = 1'b0; devsel = 1'b1; trdy = 1'b1;
  endtask

  task automatic test_read_burst();
    issue(1'b0, 32'h20, 3'd4, {4{32'hDEADBEEF}});
    checks++; if (ad !== 32'h20) begin errors++; $display("FAIL rd_addr_phase got %h want 20", ad); end
    checks++; if (cbe !== 4'b0010) begin errors++; $display("FAIL rd_cmd got %b want 0010", cbe); end
    devsel = 1'b0; trdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_early got %b want 0", rd_valid); end
      end else begin
        checks++; if ({rd_valid, rd_data, rd_beat} !== {1'b1, 32'(32'h100 + i), 2'(i - 1)})
          begin errors++; $display("FAIL rd_beat%0d_return got v=%b d=%h b=%0d want v=1 d=%h b=%0d", i - 1, rd_valid, rd_data, rd_beat, 32'h100 + i, i - 1); end
      end
      tgt_oe = 1'b1; tgt_ad = 32'(32'h101 + i);
      #1;
      checks++; if (ad !== 32'(32'h101 + i)) begin errors++; $display("FAIL rd_beat%0d_ad_not_driven got %h want %h", i, ad, 32'h101 + i); end
      checks++; if ({irdy, frame} !== {1'b0, 1'(i == 3)}) begin errors++; $display("FAIL rd_beat%0d_ctl got %b want %b", i, {irdy, frame}, {1'b0, 1'(i == 3)}); end
    end
    step();
    checks++; if ({rd_valid, rd_data, rd_beat, done} !== {1'b1, 32'h104, 2'd3, 1'b1})
      begin errors++; $display("FAIL rd_last_return got v=%b d=%h b=%0d done=%b want v=1 d=104 b=3 done=1", rd_valid, rd_data, rd_beat, done); end
    tgt_ad = 32'd0;
    #1;
    checks++; if (ad !== 32'd0) begin errors++; $display("FAIL rd_turn_ad_released got %h want 0", ad); end
    step();
    checks++; if ({rd_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rd_idle got %b want 01", {rd_valid, req_ready}); end
    tgt_oe = 1'b0; devsel = 1'b1; trdy = 1'b1;
  endtask

  task automatic test_wait_states();
    issue(1'b1, 32'h30, 3'd2, {64'd0, 32'hA1, 32'hA0});
    d0 = done_cnt;
    devsel = 1'b0; trdy = 1'b0;
    step();
    checks++; if ({ad, frame} !== {32'hA0, 1'b0}) begin errors++; $display("FAIL ws_beat0 got ad=%h frame=%b want ad=a0 frame=0", ad, frame); end
    step();
    trdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({ad, frame, irdy, done} !== {32'hA1, 1'b1, 1'b0, 1'b0})
        begin errors++; $display("FAIL ws_hold%0d got ad=%h frame=%b irdy=%b done=%b want ad=a1 frame=1 irdy=0 done=0", i, ad, frame, irdy, done); end
      if (i < 3) step();
    end
    trdy = 1'b0;
    step();
    checks++; if ({done, irdy} !== 2'b11) begin errors++; $display("FAIL ws_done got %b want 11", {done, irdy}); end
    step();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ws_done_count got %0d want %0d", done_cnt, d0 + 1); end
    devsel = 1'b1; trdy = 1'b1;
  endtask

  task automatic test_single_and_clamp();
    issue(1'b1, 32'h40, 3'd0, {96'd0, 32'hB0});
    devsel = 1'b0; trdy = 1'b0;
    step();
    checks++; if ({frame, irdy, ad} !== {1'b1, 1'b0, 32'hB0}) begin errors++; $display("FAIL single_data got frame=%b irdy=%b ad=%h want 1 0 b0", frame, irdy, ad); end
    step();
    checks++; if ({done, busy} !== 2'b11) begin errors++; $display("FAIL single_done got %b want 11", {done, busy}); end
    step();
    issue(1'b1, 32'h50, 3'd7, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({ad, frame} !== {32'(32'hC0 + i), 1'(i == 3)}) begin errors++; $display("FAIL clamp_beat%0d got ad=%h frame=%b want %h %b", i, ad, frame, 32'hC0 + i, (i == 3)); end
    end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clamp_done got %b want 1", done); end
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL clamp_idle got %b want 1", req_ready); end
    devsel = 1'b1; trdy = 1'b1;
  endtask

  task automatic test_master_abort();
    devsel = 1'b1; trdy = 1'b1;
    issue(1'b0, 32'h60, 3'd2, 128'd0);
    d0 = done_cnt;
`ifdef PCI_INIT_MASTER_ABORT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({irdy, aborted, busy} !== 3'b011) begin errors++; $display("FAIL abort_wait%0d got %b want 011", i, {irdy, aborted, busy}); end
    end
    step();
    checks++; if ({aborted, frame, irdy, done, rd_valid} !== 5'b11100) begin errors++; $display("FAIL abort_pulse got %b want 11100", {aborted, frame, irdy, done, rd_valid}); end
    step();
    checks++; if ({aborted, req_ready} !== 2'b01) begin errors++; $display("FAIL abort_idle got %b want 01", {aborted, req_ready}); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); end
`else
    for (int i = 0; i < 50; i++) step();
    checks++; if ({irdy, busy, req_ready, aborted} !== 4'b0100) begin errors++; $display("FAIL noabort_stuck got %b want 0100", {irdy, busy, req_ready, aborted}); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL noabort_no_done got %0d want %0d", done_cnt, d0); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid_burst();
    devsel = 1'b0; trdy = 1'b0;
    issue(1'b0, 32'h70, 3'd4, {4{32'hFFFFFFFF}});
    d0 = done_cnt;
    step(); tgt_oe = 1'b1; tgt_ad = 32'h201;
    step(); tgt_ad = 32'h202;
    step(); tgt_ad = 32'd0;
    rst = 1'b1;
    #1;
    checks++; if ({frame, irdy, busy, req_ready} !== 4'b1101) begin errors++; $display("FAIL rstmid_ctl got %b want 1101", {frame, irdy, busy, req_ready}); end
    checks++; if ({rd_valid, done, cbe} !== 6'b0) begin errors++; $display("FAIL rstmid_outs got %b want 000000", {rd_valid, done, cbe}); end
    checks++; if (ad !== 32'd0) begin errors++; $display("FAIL rstmid_ad_released got %h want 0", ad); end
    step();
    step();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d0); end
    rst = 1'b0; tgt_oe = 1'b0;
    issue(1'b1, 32'h80, 3'd1, {96'd0, 32'hE0});
    checks++; if ({frame, busy, ad} !== {1'b0, 1'b1, 32'h80}) begin errors++; $display("FAIL rstmid_new_req got frame=%b busy=%b ad=%h want 0 1 80", frame, busy, ad); end
    step(); step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_final_idle got %b want 1", req_ready); end
    devsel = 1'b1; trdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wait_states();
    test_single_and_clamp();
    test_master_abort();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
